pipeline_control_unit: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined RV32I core. Consumes the load-use stall request from the ID-stage hazard detector, the taken-branch/jump indication resolved in the MEM stage, and the data-memory handshake, and drives the write-enables and flush controls of the PC and all four pipeline registers. Owns a small FSM that freezes the whole pipeline during multi-cycle data-memory accesses and remembers a branch flush that arrives during a freeze. Also provides saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/core_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 40 ++++
 rtl/pipeline_control_unit.sv | 141 ++++++++++++++
 tb/tb_pipeline_control_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl_pkg
// Brief    : Shared types and defaults for the pipeline control unit.
// Revision : 1.0
// ============================================================================
package core_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int DEF_WAIT_MAX = 16;
  localparam int DEF_CNT_W    = 32;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that holds at all-ones, with synchronous clear.
// Revision : 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_control_unit
// Brief    : Stall/flush sequencer for the 5-stage RV32I pipeline.
// Revision : 1.0
// ============================================================================
module pipeline_control_unit
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WAIT_MAX = DEF_WAIT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W:0] c_wait_lim = (WAIT_W + 1)'(WAIT_MAX);

  state_e state_q, state_d;
  logic   flush_pending_q, flush_pending_d;
  logic   mem_timeout_q, mem_timeout_d;

  logic [WAIT_W-1:0] wait_cnt;
  logic              w_wait_inc;
  logic              w_wait_clr;
  logic              w_flush_evt;

  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    mem_timeout_d   = mem_timeout_q;
    w_wait_inc      = 1'b0;
    w_wait_clr      = 1'b0;
    w_flush_evt     = 1'b0;
    pc_write        = 1'b0;
    if_id_write     = 1'b0;
    id_ex_write     = 1'b0;
    ex_mem_write    = 1'b0;
    mem_wb_write    = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;

    if (!rst) begin
      case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state_d         = MEM_WAIT;
            flush_pending_d = branch_taken;
          end else if (branch_taken) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b11111;
            {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
            w_flush_evt = 1'b1;
          end else if (hazard_stall) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX.
            {id_ex_write, ex_mem_write, mem_wb_write} = 3'b111;
            id_ex_flush = 1'b1;
          end else begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b11111;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            flush_pending_d = flush_pending_q | branch_taken;
            w_wait_inc      = 1'b1;
            if (({1'b0, wait_cnt} + (WAIT_W + 1)'(1)) == c_wait_lim) begin
              mem_timeout_d = 1'b1;
            end
          end else begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b11111;
            // A flush remembered during the freeze is applied on release only.
            if (flush_pending_q || branch_taken) begin
              {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
              w_flush_evt = 1'b1;
            end
            state_d         = RUN;
            flush_pending_d = 1'b0;
            w_wait_clr      = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      flush_pending_q <= 1'b0;
      mem_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      mem_timeout_q   <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (~pc_write),
    .count_o (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (w_flush_evt),
    .count_o (flush_count)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (w_wait_clr),
    .inc_i   (w_wait_inc),
    .count_o (wait_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_control_unit
// Brief    : Directed self-checking bench with a reference model of the unit.
// Revision : 1.0
// ============================================================================
module tb_pipeline_control_unit;

  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_stall = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_control_unit #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .mem_wb_write(mem_wb_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .stall_cycles(stall_cycles), .flush_count(flush_count),
    .mem_timeout(mem_timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frozen = waiting on memory; pend = branch seen while frozen.
  bit m_frozen, m_pend, m_to;
  int m_waits, m_stall, m_flush;

  always @(negedge clk) begin
    logic [4:0] ew;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0] ef;   // {if_id, id_ex, ex_mem}
    ew = 5'b00000;
    ef = 3'b000;
    if (!rst) begin
      if (!m_frozen) begin
        if (mem_req && !mem_ready) ew = 5'b00000;
        else if (branch_taken) begin ew = 5'b11111; ef = 3'b111; end
        else if (hazard_stall) begin ew = 5'b00111; ef = 3'b010; end
        else ew = 5'b11111;
      end else if (mem_ready) begin
        ew = 5'b11111;
        if (m_pend || branch_taken) ef = 3'b111;
      end
    end
    chk("writes", int'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}), int'(ew));
    chk("flushes", int'({if_id_flush, id_ex_flush, ex_mem_flush}), int'(ef));
    chk("stall_cycles", int'(stall_cycles), m_stall);
    chk("flush_count", int'(flush_count), m_flush);
    chk("mem_timeout", int'(mem_timeout), int'(m_to));

    if (rst) begin
      m_frozen = 0; m_pend = 0; m_to = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!ew[4]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (ef[2])  m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      if (!m_frozen) begin
        if (mem_req && !mem_ready) begin m_frozen = 1; m_pend = branch_taken; end
      end else if (!mem_ready) begin
        m_pend  = m_pend | branch_taken;
        m_waits = m_waits + 1;
        if (m_waits >= WAIT_MAX) m_to = 1;
      end else begin
        m_frozen = 0; m_pend = 0; m_waits = 0;
      end
    end
  end

  task automatic apply(input logic r, input logic hs, input logic bt, input logic mq, input logic mr);
    rst = r; hazard_stall = hs; branch_taken = bt; mem_req = mq; mem_ready = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic hs, input logic bt, input logic mq, input logic mr);
    apply(r, hs, bt, mq, mr);
    tick();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    apply(1, 0, 0, 0, 0);
    chk("rst pc_write", int'(pc_write), 0);
    chk("rst mem_wb_write", int'(mem_wb_write), 0);
    tick();
    step(0, 0, 0, 0, 0);
    chk("reset stall_cycles", int'(stall_cycles), 0);

    // Load-use stall
    apply(0, 1, 0, 0, 0);
    chk("lu pc_write", int'(pc_write), 0);
    chk("lu if_id_write", int'(if_id_write), 0);
    chk("lu id_ex_flush", int'(id_ex_flush), 1);
    chk("lu mem_wb_write", int'(mem_wb_write), 1);
    tick();
    chk("lu stall_cycles", int'(stall_cycles), 1);

    // Branch overrides simultaneous stall
    apply(0, 1, 1, 0, 0);
    chk("br pc_write", int'(pc_write), 1);
    chk("br ex_mem_flush", int'(ex_mem_flush), 1);
    tick();
    chk("br flush_count", int'(flush_count), 1);
    chk("br stall_cycles", int'(stall_cycles), 1);

    // 4-cycle load
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    apply(0, 0, 0, 1, 1);
    chk("ld4 release pc_write", int'(pc_write), 1);
    tick();
    chk("ld4 stall_cycles", int'(stall_cycles), 3);
    apply(0, 1, 0, 0, 0);
    chk("ld4 back in RUN", int'(id_ex_flush), 1);
    tick();

    // Branch during freeze, ready on the 5th cycle
    do_reset();
    step(0, 0, 0, 1, 0);
    apply(0, 0, 1, 1, 0);
    chk("bw no early flush", int'(if_id_flush), 0);
    tick();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    apply(0, 0, 0, 1, 1);
    chk("bw release flush", int'(if_id_flush), 1);
    tick();
    chk("bw flush_count", int'(flush_count), 1);
    apply(0, 0, 0, 0, 0);
    chk("bw flush once", int'(ex_mem_flush), 0);
    tick();

    // Timeout on a 7-cycle load
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    chk("to not yet", int'(mem_timeout), 0);
    step(0, 0, 0, 1, 0);
    chk("to raised", int'(mem_timeout), 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("to sticky", int'(mem_timeout), 1);
    step(1, 0, 0, 0, 0);
    chk("to cleared", int'(mem_timeout), 0);

    // Reset mid-freeze with pending flush
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    apply(1, 0, 0, 1, 0);
    chk("rw rst writes", int'(id_ex_write), 0);
    tick();
    chk("rw rst stall_cycles", int'(stall_cycles), 0);
    apply(0, 0, 0, 1, 1);
    chk("rw RUN pc_write", int'(pc_write), 1);
    chk("rw no flush", int'(if_id_flush), 0);
    tick();
    chk("rw flush_count", int'(flush_count), 0);

    // Counter saturation
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    chk("sat stall_cycles", int'(stall_cycles), CNT_MAX);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
    chk("sat flush_count", int'(flush_count), CNT_MAX);

    step(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
